// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter with round-robin priority.
// One access at a time: IDLE -> ACCESS (WAIT_CYCLES strobe cycles) -> DONE (ACK pulse) -> IDLE.
// Handshake: REQx is held high with WEx/ADDRx/WDATAx stable until ACKx pulses for one
// cycle; the request is latched at grant, so later input changes never alter the
// access in flight, and a withdrawn REQ still completes and still gets its ACK.
module mem_arbiter #(
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] WDATA0,
  output logic              ACK0,
  input  logic              REQ1,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              ACK1,
  output logic [DATA_W-1:0] RDATA,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY,
  output logic              GNT_ID,
  output logic [1:0]        DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Counter starts at WAIT_CYCLES-1 so the strobe lasts WAIT_CYCLES cycles.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic                prio_q, prio_d;
  logic                gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                win;

  // State register and latched request copies; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: arbitrate in IDLE, count down in ACCESS, one ACK cycle in DONE.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    win     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          // Sole requester wins; on a tie the preferred one (prio_q) wins.
          win     = (REQ0 && REQ1) ? prio_q : REQ1;
          gnt_d   = win;
          prio_d  = ~win;
          we_d    = win ? WE1    : WE0;
          addr_d  = win ? ADDR1  : ADDR0;
          wdata_d = win ? WDATA1 : WDATA0;
          cnt_d   = CNT_INIT;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = MEM_RDATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs decode registered state only, so they are glitch-free and input-independent.
  assign MEM_READ  = (state_q == S_ACCESS) && !we_q;
  assign MEM_WRITE = (state_q == S_ACCESS) &&  we_q;
  assign ACK0      = (state_q == S_DONE) && !gnt_q;
  assign ACK1      = (state_q == S_DONE) &&  gnt_q;
  assign BUSY      = (state_q != S_IDLE);
  assign GNT_ID    = gnt_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign RDATA     = rdata_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three builds (WAIT_CYCLES 2, 1, 15) share one stimulus stream
// and are compared every cycle against a transaction-timeline reference model.
module tb_mem_arbiter;
  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int N = 3;

  function automatic int wc(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0, mem_rdata = '0;

  logic              ack0 [N];
  logic              ack1 [N];
  logic              mem_read [N];
  logic              mem_write [N];
  logic              busy [N];
  logic              gnt_id [N];
  logic [1:0]        dbg [N];
  logic [ADDR_W-1:0] mem_addr [N];
  logic [DATA_W-1:0] mem_wdata [N];
  logic [DATA_W-1:0] rdata [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int WCG = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WCG)) u_dut (
      .CLK(clk), .RST(rst),
      .REQ0(req0), .WE0(we0), .ADDR0(addr0), .WDATA0(wdata0), .ACK0(ack0[g]),
      .REQ1(req1), .WE1(we1), .ADDR1(addr1), .WDATA1(wdata1), .ACK1(ack1[g]),
      .RDATA(rdata[g]), .MEM_READ(mem_read[g]), .MEM_WRITE(mem_write[g]),
      .MEM_ADDR(mem_addr[g]), .MEM_WDATA(mem_wdata[g]), .MEM_RDATA(mem_rdata),
      .BUSY(busy[g]), .GNT_ID(gnt_id[g]), .DBG_STATE(dbg[g])
    );
  end

  // scoreboard counters and checking task
  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: age = cycles since grant (0 idle, 1..W strobe, W+1 ack).
  int                m_age [N] = '{0, 0, 0};
  logic              m_gnt [N];
  logic              m_we [N];
  logic              m_prio [N];
  logic [ADDR_W-1:0] m_addr [N];
  logic [DATA_W-1:0] m_wdata [N];
  logic [DATA_W-1:0] m_rdata [N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic w;
      if (rst) begin
        m_age[i] = 0; m_prio[i] = 0; m_gnt[i] = 0; m_we[i] = 0;
        m_addr[i] = '0; m_wdata[i] = '0; m_rdata[i] = '0;
      end else if (m_age[i] == 0) begin
        if (req0 || req1) begin
          w = (req0 && req1) ? m_prio[i] : req1;
          m_gnt[i] = w;
          m_prio[i] = !w;
          m_we[i] = w ? we1 : we0;
          m_addr[i] = w ? addr1 : addr0;
          m_wdata[i] = w ? wdata1 : wdata0;
          m_age[i] = 1;
        end
      end else if (m_age[i] == wc(i) + 1) begin
        m_age[i] = 0;
      end else begin
        if (m_age[i] == wc(i) && !m_we[i]) m_rdata[i] = mem_rdata;
        m_age[i]++;
      end
    end
  end

  // Every cycle, compare all outputs of every build against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        logic act, dn;
        act = (m_age[i] >= 1) && (m_age[i] <= wc(i));
        dn  = (m_age[i] == wc(i) + 1);
        check_eq($sformatf("mem_read[%0d]", i), 64'(mem_read[i]), 64'(act && !m_we[i]));
        check_eq($sformatf("mem_write[%0d]", i), 64'(mem_write[i]), 64'(act && m_we[i]));
        check_eq($sformatf("ack0[%0d]", i), 64'(ack0[i]), 64'(dn && !m_gnt[i]));
        check_eq($sformatf("ack1[%0d]", i), 64'(ack1[i]), 64'(dn && m_gnt[i]));
        check_eq($sformatf("busy[%0d]", i), 64'(busy[i]), 64'(m_age[i] != 0));
        check_eq($sformatf("gnt_id[%0d]", i), 64'(gnt_id[i]), 64'(m_gnt[i]));
        check_eq($sformatf("mem_addr[%0d]", i), 64'(mem_addr[i]), 64'(m_addr[i]));
        check_eq($sformatf("mem_wdata[%0d]", i), 64'(mem_wdata[i]), 64'(m_wdata[i]));
        check_eq($sformatf("rdata[%0d]", i), 64'(rdata[i]), 64'(m_rdata[i]));
        check_eq($sformatf("dbg[%0d]", i), 64'(dbg[i]), act ? 64'd1 : (dn ? 64'd2 : 64'd0));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    req0 = 0; req1 = 0;
    repeat (n) step();
  endtask

  int ack_cyc [N];
  int rd_cnt [N];
  int wr_cnt [N];
  int ack_cnt [N];
  logic gid_q[$];
  int   gcyc_q[$];

  initial begin
    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) check_eq($sformatf("rst_rdata[%0d]", i), 64'(rdata[i]), 64'd0);

    // single read by requester 0: latency and strobe width for each build
    req0 = 1; we0 = 0; addr0 = 26'h0000010; mem_rdata = 32'h20020005;
    for (int i = 0; i < N; i++) begin ack_cyc[i] = 0; rd_cnt[i] = 0; wr_cnt[i] = 0; end
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) begin
        req0 = 0;
        check_eq("rd_addr", 64'(mem_addr[0]), 64'h10);
      end
      for (int i = 0; i < N; i++) begin
        if (ack0[i] && ack_cyc[i] == 0) ack_cyc[i] = k;
        rd_cnt[i] += int'(mem_read[i]);
        wr_cnt[i] += int'(mem_write[i]);
      end
    end
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("lat_ack0[%0d]", i), 64'(ack_cyc[i]), 64'(wc(i) + 1));
      check_eq($sformatf("rd_width[%0d]", i), 64'(rd_cnt[i]), 64'(wc(i)));
      check_eq($sformatf("rd_nowr[%0d]", i), 64'(wr_cnt[i]), 64'd0);
      check_eq($sformatf("rd_data[%0d]", i), 64'(rdata[i]), 64'h20020005);
    end

    // single write by requester 1
    req1 = 1; we1 = 1; addr1 = 26'h03FFFFF; wdata1 = 32'hDEADBEEF;
    for (int i = 0; i < N; i++) begin wr_cnt[i] = 0; ack_cnt[i] = 0; end
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) req1 = 0;
      mem_rdata = $urandom;
      for (int i = 0; i < N; i++) begin
        wr_cnt[i] += int'(mem_write[i]);
        ack_cnt[i] += int'(ack1[i]);
      end
    end
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("wr_width[%0d]", i), 64'(wr_cnt[i]), 64'(wc(i)));
      check_eq($sformatf("wr_acks[%0d]", i), 64'(ack_cnt[i]), 64'd1);
      check_eq($sformatf("wr_keep_rdata[%0d]", i), 64'(rdata[i]), 64'h20020005);
    end
    we1 = 0;

    // contention from reset: grants alternate, ACKs 4 cycles apart
    rst = 1; req0 = 1; req1 = 1; addr0 = 26'h100; addr1 = 26'h200;
    step();
    rst = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (ack0[0] || ack1[0]) begin
        gid_q.push_back(ack1[0]);
        gcyc_q.push_back(k);
      end
    end
    check_eq("cont_ngrants", 64'(gid_q.size() >= 6), 64'd1);
    if (gid_q.size() > 0) check_eq("cont_first", 64'(gid_q[0]), 64'd0);
    for (int n = 1; n < gid_q.size(); n++) begin
      check_eq("cont_alt", 64'(gid_q[n]), 64'(!gid_q[n-1]));
      check_eq("cont_gap", 64'(gcyc_q[n] - gcyc_q[n-1]), 64'd4);
    end
    drain(20);

    // stability: ADDR0 changes one cycle after grant
    do_reset();
    req0 = 1; we0 = 0; addr0 = 26'h10;
    step();
    addr0 = 26'h20;
    step();
    check_eq("stab_addr", 64'(mem_addr[0]), 64'h10);
    check_eq("stab_read", 64'(mem_read[0]), 64'd1);
    step();
    check_eq("stab_ack", 64'(ack0[0]), 64'd1);
    check_eq("stab_addr_done", 64'(mem_addr[0]), 64'h10);
    drain(20);

    // reset in the second ACCESS cycle aborts the access
    do_reset();
    req0 = 1; we0 = 0; addr0 = 26'h10;
    step();
    step();
    rst = 1; req0 = 0;
    step();
    check_eq("abort_read", 64'(mem_read[0]), 64'd0);
    check_eq("abort_busy", 64'(busy[0]), 64'd0);
    check_eq("abort_ack", 64'(ack0[0]), 64'd0);
    rst = 0; req1 = 1; we1 = 0; addr1 = 26'h55;
    step();
    check_eq("after_abort_gnt", 64'(gnt_id[0]), 64'd1);
    check_eq("after_abort_addr", 64'(mem_addr[0]), 64'h55);
    drain(20);

    // randomized traffic including occasional reset
    for (int k = 0; k < 2000; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      req0 = ($urandom_range(0, 2) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      we0 = $urandom_range(0, 1);
      we1 = $urandom_range(0, 1);
      addr0 = ADDR_W'($urandom);
      addr1 = ADDR_W'($urandom);
      wdata0 = $urandom;
      wdata1 = $urandom;
      mem_rdata = $urandom;
      step();
    end
    rst = 0;
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
